// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch stage: word width, reset PC,
// fetch FSM state encoding and instruction immediate field widths.
// FETCH_PERF_EN (optional macro) adds the retired-instruction counter.
package fetch_unit_pkg;

    localparam int FU_WORD_SIZE = 16;
    localparam logic [FU_WORD_SIZE-1:0] FU_PC_RESET = 16'h0000;

    // jal carries a 12-bit absolute target; branches an 8-bit signed offset
    localparam int FU_JAL_IMM_W = 12;
    localparam int FU_BR_OFF_W  = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2,
        S_HALT  = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit_next_pc_calc.sv
// Next-PC selection for the fetch stage.
// Priority: jalr > jal > taken branch > sequential.
// All sums wrap modulo 2^WORD_SIZE.
module fetch_unit_next_pc_calc
    import fetch_unit_pkg::*;
#(
    parameter int WORD_SIZE = FU_WORD_SIZE
) (
    input  logic [WORD_SIZE-FU_JAL_IMM_W-1:0] i_pc_hi,
    input  logic [WORD_SIZE-1:0]              i_pc_plus1,
    input  logic [FU_JAL_IMM_W-1:0]           i_imm12,
    input  logic                              i_branch,
    input  logic                              i_jal,
    input  logic                              i_jalr,
    input  logic                              i_branch_taken,
    input  logic [WORD_SIZE-1:0]              i_jr_target,
    output logic [WORD_SIZE-1:0]              o_next_pc
);

    logic [WORD_SIZE-1:0] w_br_offset;
    logic [WORD_SIZE-1:0] w_br_target;
    logic [WORD_SIZE-1:0] w_jal_target;

    assign w_br_offset  = {{(WORD_SIZE-FU_BR_OFF_W){i_imm12[FU_BR_OFF_W-1]}},
                           i_imm12[FU_BR_OFF_W-1:0]};
    assign w_br_target  = i_pc_plus1 + w_br_offset;
    assign w_jal_target = {i_pc_hi, i_imm12};

    // Priority mux for the control-transfer target
    always_comb begin
        o_next_pc = i_pc_plus1;
        if (i_jalr) begin
            o_next_pc = i_jr_target;
        end else if (i_jal) begin
            o_next_pc = w_jal_target;
        end else if (i_branch && i_branch_taken) begin
            o_next_pc = w_br_target;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs the read handshake with
// instruction memory, holds the fetched word for the decoder and steps
// the PC once the datapath reports completion.
// Optional macro FETCH_PERF_EN adds the num_inst retired-instruction counter.
//
// state   | meaning
// S_IDLE  | one post-reset cycle, no memory request
// S_FETCH | readM high, address=pc, waiting for inputReady
// S_HOLD  | instr valid, waiting for exec_done from the datapath
// S_HALT  | core halted; only reset leaves this state
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int                   WORD_SIZE = FU_WORD_SIZE,
    parameter logic [WORD_SIZE-1:0] PC_RESET  = FU_PC_RESET
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic                 readM,
    output logic [WORD_SIZE-1:0] address,
    input  logic [WORD_SIZE-1:0] data,
    input  logic                 inputReady,
    output logic [WORD_SIZE-1:0] instr,
    output logic                 instr_valid,
    output logic [WORD_SIZE-1:0] pc,
    output logic [WORD_SIZE-1:0] pc_plus1,
    input  logic                 branch,
    input  logic                 jal,
    input  logic                 jalr,
    input  logic                 branch_taken,
    input  logic [WORD_SIZE-1:0] jr_target,
    input  logic                 exec_done,
    input  logic                 halt,
    output logic                 is_halted
`ifdef FETCH_PERF_EN
    ,
    output logic [WORD_SIZE-1:0] num_inst
`endif
);

    localparam logic [WORD_SIZE-1:0] ONE = 1;

    fetch_state_t         r_state;
    fetch_state_t         w_state_next;
    logic [WORD_SIZE-1:0] r_pc;
    logic [WORD_SIZE-1:0] r_instr;
    logic                 r_instr_valid;
    logic                 r_is_halted;
    logic [WORD_SIZE-1:0] w_pc_plus1;
    logic [WORD_SIZE-1:0] w_next_pc;
    logic                 w_readM;
    logic                 w_latch;
    logic                 w_retire;

    assign w_pc_plus1 = r_pc + ONE;

    fetch_unit_next_pc_calc #(
        .WORD_SIZE (WORD_SIZE)
    ) u_next_pc (
        .i_pc_hi        (r_pc[WORD_SIZE-1:FU_JAL_IMM_W]),
        .i_pc_plus1     (w_pc_plus1),
        .i_imm12        (r_instr[FU_JAL_IMM_W-1:0]),
        .i_branch       (branch),
        .i_jal          (jal),
        .i_jalr         (jalr),
        .i_branch_taken (branch_taken),
        .i_jr_target    (jr_target),
        .o_next_pc      (w_next_pc)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state and handshake strobes
    always_comb begin
        w_state_next = r_state;
        w_readM      = 1'b0;
        w_latch      = 1'b0;
        w_retire     = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_state_next = S_FETCH;
            end
            S_FETCH: begin
                w_readM = 1'b1;
                if (inputReady) begin
                    w_latch      = 1'b1;
                    w_state_next = S_HOLD;
                end
            end
            S_HOLD: begin
                if (exec_done) begin
                    w_retire     = 1'b1;
                    w_state_next = halt ? S_HALT : S_FETCH;
                end
            end
            S_HALT: begin
                w_state_next = S_HALT;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // PC, instruction latch and halt flag
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc          <= PC_RESET;
            r_instr       <= '0;
            r_instr_valid <= 1'b0;
            r_is_halted   <= 1'b0;
        end else begin
            if (w_latch) begin
                r_instr       <= data;
                r_instr_valid <= 1'b1;
            end
            if (w_retire) begin
                r_instr_valid <= 1'b0;
                if (halt) begin
                    r_is_halted <= 1'b1;
                end else begin
                    r_pc <= w_next_pc;
                end
            end
        end
    end

`ifdef FETCH_PERF_EN
    logic [WORD_SIZE-1:0] r_num_inst;

    // Retired-instruction counter; the HLT itself counts, wraps freely
    always_ff @(posedge clk) begin
        if (reset) begin
            r_num_inst <= '0;
        end else if (w_retire) begin
            r_num_inst <= r_num_inst + ONE;
        end
    end

    assign num_inst = r_num_inst;
`endif

    // Address is only driven with the PC while a read is outstanding
    assign readM       = w_readM;
    assign address     = w_readM ? r_pc : '0;
    assign instr       = r_instr;
    assign instr_valid = r_instr_valid;
    assign pc          = r_pc;
    assign pc_plus1    = w_pc_plus1;
    assign is_halted   = r_is_halted;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized
// run checked against a behavioural next-PC / retirement model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        readM;
    logic [15:0] address;
    logic [15:0] data;
    logic        inputReady;
    logic [15:0] instr;
    logic        instr_valid;
    logic [15:0] pc;
    logic [15:0] pc_plus1;
    logic        branch;
    logic        jal;
    logic        jalr;
    logic        branch_taken;
    logic [15:0] jr_target;
    logic        exec_done;
    logic        halt;
    logic        is_halted;
`ifdef FETCH_PERF_EN
    logic [15:0] num_inst;
`endif

    int errors = 0;
    int checks = 0;

    logic [15:0] m_pc;
    logic [15:0] m_instr;
    int          m_count;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk          (clk),
        .reset        (reset),
        .readM        (readM),
        .address      (address),
        .data         (data),
        .inputReady   (inputReady),
        .instr        (instr),
        .instr_valid  (instr_valid),
        .pc           (pc),
        .pc_plus1     (pc_plus1),
        .branch       (branch),
        .jal          (jal),
        .jalr         (jalr),
        .branch_taken (branch_taken),
        .jr_target    (jr_target),
        .exec_done    (exec_done),
        .halt         (halt),
        .is_halted    (is_halted)
`ifdef FETCH_PERF_EN
        ,
        .num_inst     (num_inst)
`endif
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] ref_next(input logic [15:0] p, input logic [15:0] ins,
                                             input logic b, input logic j, input logic jr,
                                             input logic t, input logic [15:0] tgt);
        int off;
        int s;
        off = int'(ins[7:0]);
        if (off >= 128) off = off - 256;
        if (jr) return tgt;
        if (j) return {p[15:12], ins[11:0]};
        if (b && t) begin
            s = (int'(p) + 1 + off) % 65536;
            if (s < 0) s = s + 65536;
            return 16'(s);
        end
        return 16'((int'(p) + 1) % 65536);
    endfunction

    task automatic perf_chk(input string tag);
`ifdef FETCH_PERF_EN
        chk(tag, num_inst, 16'(m_count));
`else
        chk(tag, 16'(is_halted), 16'(is_halted === 1'b1 ? 1 : 0));
`endif
    endtask

    // Reset for two edges, release, and land in S_FETCH
    task automatic do_reset();
        reset = 1'b1; inputReady = 1'b0; exec_done = 1'b0; halt = 1'b0;
        @(negedge clk);
        @(negedge clk);
        m_pc = 16'h0000; m_count = 0;
        chk("rst_readM", 16'(readM), 16'h0);
        chk("rst_addr", address, 16'h0000);
        chk("rst_instr", instr, 16'h0000);
        chk("rst_valid", 16'(instr_valid), 16'h0);
        chk("rst_halted", 16'(is_halted), 16'h0);
        chk("rst_pc", pc, 16'h0000);
`ifdef FETCH_PERF_EN
        chk("rst_num_inst", num_inst, 16'h0000);
`endif
        reset = 1'b0;
        @(negedge clk);
    endtask

    // Memory returns `word` after `waits` wait cycles
    task automatic fetch(input logic [15:0] word, input int waits);
        for (int i = 0; i < waits; i++) begin
            chk("fetch_wait_readM", 16'(readM), 16'h1);
            chk("fetch_wait_addr", address, m_pc);
            @(negedge clk);
        end
        chk("fetch_readM", 16'(readM), 16'h1);
        chk("fetch_addr", address, m_pc);
        inputReady = 1'b1; data = word;
        @(negedge clk);
        inputReady = 1'b0; data = 16'($urandom);
        m_instr = word;
        chk("latch_instr", instr, word);
        chk("latch_valid", 16'(instr_valid), 16'h1);
        chk("latch_readM", 16'(readM), 16'h0);
        chk("latch_pc", pc, m_pc);
        chk("latch_pc_plus1", pc_plus1, m_pc + 16'h1);
    endtask

    // Idle cycles in S_HOLD with noise on ignored inputs
    task automatic hold(input int n);
        for (int i = 0; i < n; i++) begin
            inputReady = 1'($urandom); data = 16'($urandom);
            @(negedge clk);
            inputReady = 1'b0;
            chk("hold_instr", instr, m_instr);
            chk("hold_valid", 16'(instr_valid), 16'h1);
            chk("hold_readM", 16'(readM), 16'h0);
            chk("hold_pc", pc, m_pc);
        end
    endtask

    task automatic execute(input logic b, input logic j, input logic jr, input logic t,
                           input logic [15:0] tgt, input logic h);
        branch = b; jal = j; jalr = jr; branch_taken = t; jr_target = tgt; halt = h;
        exec_done = 1'b1;
        @(negedge clk);
        exec_done = 1'b0; halt = 1'($urandom);
        branch = 1'($urandom); jal = 1'($urandom); jalr = 1'($urandom);
        branch_taken = 1'($urandom); jr_target = 16'($urandom);
        m_count++;
        if (!h) m_pc = ref_next(m_pc, m_instr, b, j, jr, t, tgt);
        chk("exec_valid", 16'(instr_valid), 16'h0);
        chk("exec_halted", 16'(is_halted), 16'(h));
        chk("exec_readM", 16'(readM), 16'(!h));
        chk("exec_pc", pc, m_pc);
        chk("exec_addr", address, h ? 16'h0000 : m_pc);
        perf_chk("exec_num_inst");
    endtask

    initial begin
        reset = 1'b1; data = 16'h0; inputReady = 1'b0; branch = 1'b0; jal = 1'b0;
        jalr = 1'b0; branch_taken = 1'b0; jr_target = 16'h0; exec_done = 1'b0; halt = 1'b0;
        m_pc = 16'h0; m_instr = 16'h0; m_count = 0;

        do_reset();
        fetch(16'h4105, 2);

        // taken backward branch from 0010
        execute(1'b0, 1'b0, 1'b1, 1'b0, 16'h0010, 1'b0);
        fetch(16'h12FE, 0);
        execute(1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0);
        chk("br_taken_addr", address, 16'h000F);

        // not-taken branch from 0010
        fetch(16'h0001, 1);
        execute(1'b0, 1'b0, 1'b1, 1'b0, 16'h0010, 1'b0);
        fetch(16'h12FE, 1);
        execute(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
        chk("br_not_taken_addr", address, 16'h0011);

        // jal from 3005, then jalr beating jal
        fetch(16'h0002, 0);
        execute(1'b0, 1'b0, 1'b1, 1'b0, 16'h3005, 1'b0);
        fetch(16'h5ABC, 3);
        chk("jal_pc_plus1", pc_plus1, 16'h3006);
        execute(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
        chk("jal_addr", address, 16'h3ABC);
        fetch(16'h5ABC, 0);
        execute(1'b0, 1'b1, 1'b1, 1'b0, 16'h1234, 1'b0);
        chk("jalr_prio_addr", address, 16'h1234);

        // wrap at FFFF
        fetch(16'h0003, 0);
        execute(1'b0, 1'b0, 1'b1, 1'b0, 16'hFFFF, 1'b0);
        fetch(16'h0000, 1);
        chk("wrap_pc_plus1", pc_plus1, 16'h0000);
        execute(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
        chk("wrap_addr", address, 16'h0000);

        // randomized run against the model
        for (int n = 0; n < 40; n++) begin
            fetch(16'($urandom), int'($urandom_range(0, 3)));
            hold(int'($urandom_range(0, 2)));
            execute(1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0),
                    1'($urandom), 16'($urandom), 1'b0);
        end

        // halt and stay halted
        fetch(16'hF000, 1);
        execute(1'b1, 1'b1, 1'b0, 1'b1, 16'h5555, 1'b1);
        for (int i = 0; i < 20; i++) begin
            exec_done = 1'($urandom); halt = 1'($urandom); inputReady = 1'($urandom);
            jalr = 1'($urandom); jr_target = 16'($urandom); data = 16'($urandom);
            @(negedge clk);
            chk("halt_readM", 16'(readM), 16'h0);
            chk("halt_flag", 16'(is_halted), 16'h1);
            chk("halt_pc", pc, m_pc);
            chk("halt_valid", 16'(instr_valid), 16'h0);
            perf_chk("halt_num_inst");
        end
        exec_done = 1'b0; inputReady = 1'b0;

        do_reset();
        chk("post_halt_pc", pc, 16'h0000);
        chk("post_halt_readM", 16'(readM), 16'h1);

        // reset colliding with inputReady mid-fetch, then a late inputReady
        @(negedge clk);
        reset = 1'b1; inputReady = 1'b1; data = 16'hABCD;
        @(negedge clk);
        reset = 1'b0;
        chk("rstcol_instr", instr, 16'h0000);
        chk("rstcol_valid", 16'(instr_valid), 16'h0);
        chk("rstcol_readM", 16'(readM), 16'h0);
        @(negedge clk);
        inputReady = 1'b0;
        chk("late_ready_instr", instr, 16'h0000);
        chk("late_ready_valid", 16'(instr_valid), 16'h0);
        chk("late_ready_readM", 16'(readM), 16'h1);
        m_pc = 16'h0000; m_count = 0;
        perf_chk("rstcol_num_inst");

        // three retirements after reset
        for (int i = 0; i < 3; i++) begin
            fetch(16'($urandom) & 16'h00FF, i);
            execute(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
        end
        chk("three_retired_pc", pc, 16'h0003);
`ifdef FETCH_PERF_EN
        chk("three_retired_num_inst", num_inst, 16'h0003);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the control-unit decoder in the 16-bit single-issue CPU.
- Owns the PC and runs a read handshake with instruction memory.
- Presents a stable instruction word plus a valid flag to the decoder and datapath.
- Computes the next PC from the decoder's branch/jal/jalr outputs and the datapath's branch condition, then refetches once the datapath signals completion.

Parameters:
- WORD_SIZE, 16, width of instruction, address and PC.
- PC_RESET, 16'h0000, PC value loaded on reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- readM  out  1  instruction-memory read request.
- address  out  WORD_SIZE  instruction-memory address (equals pc while readM=1).
- data  in  WORD_SIZE  instruction word from memory; valid when inputReady=1.
- inputReady  in  1  memory read-complete strobe.
- instr  out  WORD_SIZE  latched instruction, fed to decoder.
- instr_valid  out  1  instr holds a fetched instruction awaiting execution.
- pc  out  WORD_SIZE  address of instr.
- pc_plus1  out  WORD_SIZE  pc+1, for link-register write.
- branch  in  1  decoder: control-transfer instruction.
- jal  in  1  decoder: absolute jump.
- jalr  in  1  decoder: register jump.
- branch_taken  in  1  datapath: branch condition true.
- jr_target  in  WORD_SIZE  datapath: register value for jalr target.
- exec_done  in  1  datapath: current instruction finished, pulse.
- halt  in  1  datapath: current instruction is HLT.
- is_halted  out  1  core halted.
- num_inst  out  WORD_SIZE  retired-instruction count (only with FETCH_PERF_EN).

Behaviour:
- Clocking: one clock clk; reset is synchronous and active-high.
- Reset values: pc=PC_RESET, readM=0, address=0, instr=0, instr_valid=0, is_halted=0, num_inst=0, state=S_IDLE.
- States: S_IDLE, S_FETCH, S_HOLD, S_HALT.
- S_IDLE: unconditionally go to S_FETCH on the next edge. Gives one post-reset cycle with readM=0.
- S_FETCH:
  - readM=1 and address=pc, held stable until inputReady.
  - On inputReady=1: instr<=data, instr_valid<=1, readM<=0 on the same edge, go to S_HOLD.
  - Zero-wait memory (inputReady asserted in the first S_FETCH cycle) costs exactly one fetch cycle.
- S_HOLD:
  - readM=0; instr, pc and instr_valid held stable.
  - Waits for exec_done. On exec_done=1 with halt=0: pc<=next_pc, instr_valid<=0, go to S_FETCH.
  - On exec_done=1 with halt=1: pc unchanged, instr_valid<=0, is_halted<=1, go to S_HALT.
- S_HALT: absorbing state, left only by reset. readM stays 0.
- Next-PC priority (combinational from instr and pc):
  - jalr=1: jr_target.
  - else jal=1: {pc[15:12], instr[11:0]}.
  - else branch=1 and branch_taken=1: pc+1+sign_extend(instr[7:0]).
  - else: pc+1.
- Arithmetic: all sums are modulo 2^16. pc=16'hFFFF with no branch wraps to 16'h0000. Negative offsets wrap the same way.
- Ignored inputs:
  - inputReady outside S_FETCH.
  - exec_done and halt outside S_HOLD.
  - branch_taken when branch=0.
- Simultaneous events: if reset and inputReady or exec_done occur in the same cycle, reset wins and no instruction is latched or retired.
- Reset mid-fetch: readM is 0 from the cycle after the reset edge; a late inputReady is ignored while in S_IDLE.
- pc_plus1 = pc+1, combinational, also wrapping.

Optional Feature:
- Macro FETCH_PERF_EN.
- Defined:
  - num_inst port exists; a 16-bit counter increments on every exec_done accepted in S_HOLD, including the HLT itself.
  - Counter wraps 16'hFFFF->0 and is cleared by reset.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared include opcodes.v (already holds WORD_SIZE): add the fetch state encodings (S_IDLE=2'd0, S_FETCH=2'd1, S_HOLD=2'd2, S_HALT=2'd3) and PC_RESET.
- One natural sub-module, next_pc_calc: purely combinational, implementing the priority mux and sign extension.
- FSM, PC register and instruction latch stay in fetch_unit.

Test Plan:
- Reset release, memory returns 16'h4105 after 2 wait cycles: readM rises 1 cycle after reset; address=0000; instr=4105 and instr_valid=1 one edge after inputReady; readM=0.
- pc=0010, branch=1, branch_taken=1, instr[7:0]=FE, exec_done: next fetch address=000F. With branch_taken=0: address=0011.
- pc=3005, jal=1, instr[11:0]=0ABC: next address=3ABC, pc_plus1=3006. jalr=1 with jr_target=1234 and jal=1 also set: next address=1234 (jalr priority).
- pc=FFFF, plain ALU instruction, exec_done: next address=0000.
- Halt: exec_done=1, halt=1 → is_halted=1, readM stays 0 for 20 cycles, pc unchanged. Further exec_done pulses have no effect. Reset returns pc to 0000.
- Reset asserted during S_FETCH with inputReady in the same cycle: instr stays 0000, instr_valid=0; with FETCH_PERF_EN, num_inst=0 and 3 retired instructions then give num_inst=3.
